// File: rtl/rnd_scheduler_if.sv
// Handshake bundle between the random-sample scheduler and its environment:
// generator sample in, level requests in, grant pulse / sample / status out.
interface rnd_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] rnd_in;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  gnt;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             busy;

  modport master (
    output rnd_in,
    output req,
    input  gnt,
    input  data_out,
    input  data_valid,
    input  busy
  );

  modport slave (
    input  rnd_in,
    input  req,
    output gnt,
    output data_out,
    output data_valid,
    output busy
  );
endinterface

// File: rtl/rnd_scheduler.sv
// Round-robin sharing of one free-running LFSR sample among NREQ consumers, with a
// MIN_GAP idle window after each grant. Optional macro RND_NO_REPEAT_EN blocks per-requester repeats.
module rnd_scheduler #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 4,
  parameter int MIN_GAP = 2
) (
  input logic            clock,
  input logic            reset,
  rnd_scheduler_if.slave bus
);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP + 1) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);
  localparam logic [PTR_W:0]   NREQ_W   = (PTR_W + 1)'(NREQ);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP);
  localparam logic [NREQ-1:0]  ONE_HOT0 = {{(NREQ - 1){1'b0}}, 1'b1};

  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]  data_out_q, data_out_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  logic [2*NREQ-1:0] rot_s;
  logic [PTR_W-1:0]  off_s;
  logic [PTR_W:0]    sum_s;
  logic [PTR_W-1:0]  win_s;
  logic              found_s;
  logic              cancel_s;
  logic              grant_s;

  // Rotate requests so bit 0 is the rr_ptr requester, then take the first set bit.
  always_comb begin
    rot_s   = {bus.req, bus.req} >> rr_ptr_q;
    found_s = 1'b0;
    off_s   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found_s && rot_s[i]) begin
        found_s = 1'b1;
        off_s   = PTR_W'(i);
      end else begin
        found_s = found_s;
      end
    end
    sum_s = {1'b0, rr_ptr_q} + {1'b0, off_s};
    if (sum_s >= NREQ_W) begin
      sum_s = sum_s - NREQ_W;
    end else begin
      sum_s = sum_s;
    end
    win_s = sum_s[PTR_W-1:0];
  end

`ifdef RND_NO_REPEAT_EN
  logic [WIDTH-1:0] last_q [NREQ];
  logic [NREQ-1:0]  last_vld_q;

  // A winner about to receive the same value it got last time is held off one cycle.
  always_comb begin
    if (last_vld_q[win_s] && (last_q[win_s] == bus.rnd_in)) begin
      cancel_s = 1'b1;
    end else begin
      cancel_s = 1'b0;
    end
  end

  // Remember the last sample handed to each requester.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) begin
        last_q[i] <= '0;
      end
      last_vld_q <= '0;
    end else if (grant_s) begin
      last_q[win_s]     <= bus.rnd_in;
      last_vld_q[win_s] <= 1'b1;
    end else begin
      last_vld_q <= last_vld_q;
    end
  end
`else
  assign cancel_s = 1'b0;
`endif

  assign grant_s = (gap_cnt_q == '0) && found_s && !cancel_s;

  // Next-state: gap countdown, or a grant with pointer advance and sample capture.
  always_comb begin
    gap_cnt_d  = gap_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = '0;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    if (gap_cnt_q != '0) begin
      gap_cnt_d = gap_cnt_q - GAP_W'(1);
    end else if (grant_s) begin
      gap_cnt_d  = GAP_LOAD;
      rr_ptr_d   = (win_s == LAST_IDX) ? '0 : (win_s + PTR_W'(1));
      gnt_d      = ONE_HOT0 << win_s;
      data_out_d = bus.rnd_in;
      valid_d    = 1'b1;
    end else begin
      gap_cnt_d = gap_cnt_q;
    end
    busy_d = valid_d | (gap_cnt_d != '0);
  end

  // State and output registers; reset drops any grant in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gap_cnt_q  <= '0;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      gap_cnt_q  <= gap_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = valid_q;
  assign bus.busy       = busy_q;
endmodule
